// File: rtl/mcc_pkg.sv
// ============================================================================
// Module      : mcc_pkg
// Description : Shared opcode/state encodings for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcc_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_JMP  = 2'b10,
        OP_HALT = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mcc_decode.sv
// ============================================================================
// Module      : mcc_decode
// Description : Splits the instruction register into opcode, register select
//               and immediate fields. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcc_decode
    import mcc_pkg::*;
#(
    parameter int  RSEL_W  = 1,
    parameter int  IMM_W   = 2,
    localparam int INSTR_W = OP_W + RSEL_W + IMM_W
)(
    input  logic [INSTR_W-1:0] i_ir,
    output logic [OP_W-1:0]    o_opcode,
    output logic [RSEL_W-1:0]  o_rsel,
    output logic [IMM_W-1:0]   o_imm
);

    // Opcode occupies the top bits, register select sits just above the immediate
    assign o_opcode = i_ir[INSTR_W-1 -: OP_W];
    assign o_rsel   = i_ir[IMM_W +: RSEL_W];
    assign o_imm    = i_ir[IMM_W-1:0];

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Four-phase (fetch/decode/execute/writeback) controller for a
//               tiny ADD/SUB/JMP/HALT instruction set with external
//               instruction memory and register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mcc_pkg::*;
#(
    parameter int  DATA_W  = 4,
    parameter int  NREGS   = 2,
    parameter int  PC_W    = 4,
    parameter int  IMM_W   = 2,
    localparam int RSEL_W  = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int INSTR_W = OP_W + RSEL_W + IMM_W
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [RSEL_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0]  rf_rdata,
    output logic               rf_we,
    output logic [RSEL_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               carry,
    output logic               halted,
    output logic [2:0]         state_o
);

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_operand;
    logic [DATA_W-1:0]   r_result;
    logic                r_carry;

    logic [OP_W-1:0]     w_op_bits;
    opcode_t             w_opcode;
    logic [RSEL_W-1:0]   w_rsel;
    logic [IMM_W-1:0]    w_imm;
    logic                w_is_alu;
    logic [DATA_W:0]     w_imm_ext;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [PC_W-1:0]     w_jmp_pc;

    mcc_decode #(
        .RSEL_W (RSEL_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .i_ir     (r_ir),
        .o_opcode (w_op_bits),
        .o_rsel   (w_rsel),
        .o_imm    (w_imm)
    );

    assign w_opcode = opcode_t'(w_op_bits);
    assign w_is_alu = (w_opcode == OP_ADD) || (w_opcode == OP_SUB);

    // Immediate widened to the DATA_W+1 arithmetic width (zero-extend or truncate)
    generate
        if (IMM_W <= DATA_W) begin : g_imm_zext
            assign w_imm_ext = {{(DATA_W + 1 - IMM_W){1'b0}}, w_imm};
        end else begin : g_imm_trunc
            assign w_imm_ext = w_imm[DATA_W:0];
        end
    endgenerate

    // Jump target sized to the program counter (zero-extend or truncate)
    generate
        if (IMM_W < PC_W) begin : g_pc_zext
            assign w_jmp_pc = {{(PC_W - IMM_W){1'b0}}, w_imm};
        end else begin : g_pc_trunc
            assign w_jmp_pc = w_imm[PC_W-1:0];
        end
    endgenerate

    // Top bit of the difference is the borrow: set exactly when operand < imm
    assign w_sum  = {1'b0, r_operand} + w_imm_ext;
    assign w_diff = {1'b0, r_operand} - w_imm_ext;

    assign imem_addr = r_pc;
    assign rf_raddr  = w_rsel;
    assign rf_waddr  = w_rsel;
    assign rf_wdata  = r_result;
    assign carry     = r_carry;
    assign state_o   = r_state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode; strobes depend only on registered state/IR
    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_next_state = (w_opcode == OP_HALT) ? ST_HALT : ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                rf_we        = w_is_alu;
                w_next_state = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: IR, operand, result/carry and program counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_operand <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_valid) begin
                        r_ir <= imem_rdata;
                    end
                end
                ST_DECODE: begin
                    r_operand <= rf_rdata;
                end
                ST_EXECUTE: begin
                    // JMP and HALT leave the carry flag untouched
                    if (w_opcode == OP_ADD) begin
                        r_result <= w_sum[DATA_W-1:0];
                        r_carry  <= w_sum[DATA_W];
                    end else if (w_opcode == OP_SUB) begin
                        r_result <= w_diff[DATA_W-1:0];
                        r_carry  <= w_diff[DATA_W];
                    end
                end
                ST_WRITEBACK: begin
                    if (w_is_alu) begin
                        r_pc <= r_pc + PC_W'(1);
                    end else begin
                        r_pc <= w_jmp_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 4, giving the datapath and register width.
REQ-002 SHALL have parameter NREGS, default 2, giving the register count; RSEL_W = max(1, clog2(NREGS)).
REQ-003 SHALL have parameter PC_W, default 4, giving the program counter width.
REQ-004 SHALL have parameter IMM_W, default 2, giving the immediate width; INSTR_W = 2 + RSEL_W + IMM_W.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 run  in  1  start request, level-sampled in IDLE.
REQ-008 imem_req  out  1  instruction fetch request.
REQ-009 imem_addr  out  PC_W  fetch address, equal to PC.
REQ-010 imem_rdata  in  INSTR_W  fetched instruction.
REQ-011 imem_valid  in  1  imem_rdata valid this cycle.
REQ-012 rf_raddr  out  RSEL_W  register read select; read data returns combinationally.
REQ-013 rf_rdata  in  DATA_W  register read data.
REQ-014 rf_we  out  1  register write strobe.
REQ-015 rf_waddr  out  RSEL_W  register write select.
REQ-016 rf_wdata  out  DATA_W  register write data.
REQ-017 carry  out  1  carry/borrow flag from the last ADD/SUB.
REQ-018 halted  out  1  high while in HALT.
REQ-019 state_o  out  3  current FSM state encoding.

Function
REQ-020 Instruction fields SHALL be: opcode = instr[INSTR_W-1 -: 2], rsel = next RSEL_W bits, imm = low IMM_W bits.
REQ-021 Opcodes SHALL be: 00 ADD (R[rsel] += imm), 01 SUB (R[rsel] -= imm), 10 JMP (PC = imm zero-extended or truncated to PC_W), 11 HALT.
REQ-022 FSM states SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
REQ-023 IDLE SHALL go to FETCH when run=1; otherwise it SHALL stay in IDLE.
REQ-024 FETCH SHALL drive imem_req=1 and imem_addr=PC, stay in FETCH while imem_valid=0, and on imem_valid=1 latch imem_rdata into IR and go to DECODE.
REQ-025 DECODE SHALL drive rf_raddr=IR.rsel, latch rf_rdata into the operand register, and go to EXECUTE.
REQ-026 EXECUTE SHALL compute the result as a DATA_W+1-bit sum or difference with imm zero-extended; result = low DATA_W bits.
REQ-027 EXECUTE SHALL set carry = bit DATA_W for ADD, and carry = borrow (operand < imm) for SUB.
REQ-028 EXECUTE SHALL route HALT to HALT; all other opcodes SHALL go to WRITEBACK.
REQ-029 WRITEBACK for ADD/SUB SHALL assert rf_we for exactly one cycle with rf_waddr=IR.rsel and rf_wdata=result, and set PC=PC+1 modulo 2^PC_W.
REQ-030 WRITEBACK for JMP SHALL leave rf_we=0 and set PC=imm; the next state SHALL always be FETCH.
REQ-031 HALT SHALL hold halted=1 and all strobes low, and leave only by reset.
REQ-032 With imem_valid tied high, every non-HALT instruction SHALL take exactly 4 cycles from FETCH entry to the next FETCH entry.
REQ-033 imem_req and rf_we SHALL be registered-state decodes, free of glitches, and never high in the same cycle.
REQ-034 Wrap boundaries: PC all-ones + 1 SHALL give 0; all-ones + 1 SHALL give 0 with carry=1; 0 - 1 SHALL give all-ones with carry=1.
REQ-035 carry SHALL be unchanged by JMP and HALT.

Reset
REQ-036 rst=0 SHALL immediately force state IDLE, PC=0, IR=0, operand=0, carry=0, imem_req=0, rf_we=0 and halted=0.
REQ-037 Reset asserted mid-FETCH or mid-WRITEBACK SHALL abort with no register write and no PC update after the reset edge.
REQ-038 After rst rises, the first FETCH SHALL occur one cycle after run is sampled high.

Structure
REQ-039 Package mcc_pkg SHALL hold the opcode enum, the state enum, and the OP_W=2 constant.
REQ-040 A combinational sub-module mcc_decode SHALL split IR into opcode, rsel and imm fields.

Verification
REQ-041 Defaults, imem={ADD r0,3} then HALT, imem_valid=1, rf_rdata=2 -> rf_we pulse with wdata=5, carry=0; halted=1 at cycle 8.
REQ-042 ADD with rf_rdata=4'hF, imm=1 -> wdata=0, carry=1; SUB with rf_rdata=0, imm=1 -> wdata=4'hF, carry=1.
REQ-043 imem_valid held low 3 cycles in FETCH -> imem_req stays high 4 cycles, IR latched only on the valid cycle, instruction takes 7 cycles.
REQ-044 JMP 2 at PC=1 -> no rf_we; the next imem_addr=2. Program without HALT -> PC wraps from 15 to 0.
REQ-045 rst=0 asserted during WRITEBACK -> rf_we low at once, state_o=0, PC=0; no write observed.
